// File: rtl/stim_sched.sv
// Stimulus scheduler: queues 5-bit vectors, drives them one at a time to a
// downstream combinational stage, waits LAT settle cycles, and captures o/p.
module stim_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] in_vec,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    input  logic       o,
    input  logic       p,
    output logic       res_o,
    output logic       res_p,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic [7:0] res_cnt
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    logic [4:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [4:0]        r_drive;
    logic              r_res_o;
    logic              r_res_p;
    logic              r_res_valid;
    logic              r_busy;
    logic [7:0]        r_res_cnt;
    logic              w_push;
    logic              w_pop;

    // Ready depends only on the registered occupancy, never on the pop.
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_count != '0);

    // Storage needs no reset: occupancy tracking alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue / settle / capture / hand-off sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_drive     <= '0;
            r_res_o     <= 1'b0;
            r_res_p     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_res_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_drive <= r_mem[r_rd_ptr];
                        r_wait  <= WAIT_W'(LAT);
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_CAP;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                S_CAP: begin
                    r_res_o     <= o;
                    r_res_p     <= p;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_cnt   <= r_res_cnt + 8'd1;
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {e, d, c, b, a} = r_drive;
    assign res_o           = r_res_o;
    assign res_p           = r_res_p;
    assign res_valid       = r_res_valid;
    assign busy            = r_busy;
    assign res_cnt         = r_res_cnt;

endmodule
